uart_mmio: RTL and testbench

Memory-mapped UART console port for the hxd32 core: CPU loads/stores on the data bus become bytes queued to `uart_tx` and bytes received by `uart_rx` become readable words. It is the CPU-side responder to the core's data-bus initiator and the opposite direction to the UART-to-RAM loader: software reaches the host link instead of the host reaching RAM. It sits beside `ram` on the data bus and in front of the existing `uart_tx`/`uart_rx` instances; the parent performs address decode.

---
 rtl/hxd_uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_mmio.sv | 117 +++++++++++
 tb/tb_uart_mmio.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hxd_uart_pkg.sv
// Shared constants for the hxd32 memory-mapped UART console port:
// register offsets, STATUS bit positions and the reset baud divisor.
package hxd_uart_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int ST_RX_VLD   = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_OVF   = 4;

  localparam logic [31:0] BAUD_DEFAULT = 32'd107;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == (PW+1)'(DEPTH));
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define validity, and this lets the array map onto plain RAM cells.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// CPU-side MMIO responder bridging data-bus loads/stores to uart_tx/uart_rx
// through two byte FIFOs, plus sticky overflow flags and the baud divisor.
module uart_mmio
  import hxd_uart_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BAUD_RST   = BAUD_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mmio_rd_en_i,
  input  logic [XLEN-1:0] mmio_rd_addr_i,
  output logic [XLEN-1:0] mmio_rd_data_o,
  input  logic [XLEN-1:0] mmio_wr_addr_i,
  input  logic [XLEN-1:0] mmio_wr_data_i,
  input  logic [3:0]      mmio_wr_byte_en_i,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  input  logic [7:0]      uart_rx_data_i,
  input  logic            uart_rx_data_vld_i,
  output logic            uart_rx_data_rdy_o,
  output logic [31:0]     uart_baud_div_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_off_e       rd_off;
  reg_off_e       wr_off;
  logic           wr;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     tx_head, rx_head;
  logic [CW-1:0]  tx_count, rx_count;
  logic           tx_ovf, rx_ovf;
  logic [31:0]    baud;
  logic [XLEN-1:0] status_word;
  logic [XLEN-1:0] rd_next;
  logic           unused_ok;

  assign rd_off = reg_off_e'(mmio_rd_addr_i[3:2]);
  assign wr_off = reg_off_e'(mmio_wr_addr_i[3:2]);
  assign wr     = |mmio_wr_byte_en_i;

  assign tx_push = wr && (wr_off == REG_DATA) && mmio_wr_byte_en_i[0];
  assign tx_pop  = !tx_empty && uart_tx_data_rdy_i;
  assign rx_push = uart_rx_data_vld_i && !rx_full;
  assign rx_pop  = mmio_rd_en_i && (rd_off == REG_DATA) && !rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_i(tx_push), .push_data_i(mmio_wr_data_i[7:0]), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_i(rx_push), .push_data_i(uart_rx_data_i), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  // The stale head is masked so the TX byte reads 0 whenever nothing is offered.
  assign uart_tx_data_o     = tx_empty ? 8'h00 : tx_head;
  assign uart_tx_data_vld_o = !tx_empty;
  assign uart_rx_data_rdy_o = !rx_full;
  assign uart_baud_div_o    = baud;

  always_comb begin
    status_word              = '0;
    status_word[ST_RX_VLD]   = !rx_empty;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_TX_OVF]   = tx_ovf;
    status_word[ST_RX_OVF]   = rx_ovf;
  end

  // NOTE: rd_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_next = '0;
    case (rd_off)
      REG_DATA:   rd_next = rx_empty ? '0 : XLEN'(rx_head);
      REG_STATUS: rd_next = status_word;
      REG_BAUD:   rd_next = XLEN'(baud);
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mmio_rd_data_o <= '0;
      tx_ovf         <= 1'b0;
      rx_ovf         <= 1'b0;
      baud           <= BAUD_RST;
    end else begin
      if (mmio_rd_en_i) mmio_rd_data_o <= rd_next;
      if (wr && (wr_off == REG_STATUS)) begin
        if (mmio_wr_data_i[ST_TX_OVF]) tx_ovf <= 1'b0;
        if (mmio_wr_data_i[ST_RX_OVF]) rx_ovf <= 1'b0;
      end
      if (wr && (wr_off == REG_BAUD)) begin
        for (int b = 0; b < 4; b++) begin
          if (mmio_wr_byte_en_i[b]) baud[8*b +: 8] <= mmio_wr_data_i[8*b +: 8];
        end
      end
      // A new overflow event takes precedence over a same-cycle clear.
      if (tx_push && tx_full && !tx_pop)              tx_ovf <= 1'b1;
      if (uart_rx_data_vld_i && !uart_rx_data_rdy_o)  rx_ovf <= 1'b1;
    end
  end

  assign unused_ok = ^{mmio_rd_addr_i[XLEN-1:4], mmio_rd_addr_i[1:0],
                       mmio_wr_addr_i[XLEN-1:4], mmio_wr_addr_i[1:0],
                       tx_count, rx_count};

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: queue-based reference model checked
// every cycle, plus directed register-level checks with literal expectations.
module tb_uart_mmio;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  be = '0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_vld = 1'b0;
  logic        rx_rdy;
  logic [31:0] baud;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_mmio #(.XLEN(32), .FIFO_DEPTH(DEPTH), .BAUD_RST(32'd107)) dut (
    .clk_i(clk), .rst_i(rst),
    .mmio_rd_en_i(rd_en), .mmio_rd_addr_i(rd_addr), .mmio_rd_data_o(rd_data),
    .mmio_wr_addr_i(wr_addr), .mmio_wr_data_i(wr_data), .mmio_wr_byte_en_i(be),
    .uart_tx_data_o(tx_data), .uart_tx_data_vld_o(tx_vld), .uart_tx_data_rdy_i(tx_rdy),
    .uart_rx_data_i(rx_data), .uart_rx_data_vld_i(rx_vld), .uart_rx_data_rdy_o(rx_rdy),
    .uart_baud_div_o(baud)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic        m_tx_ovf, m_rx_ovf;
  logic [31:0] m_baud;
  logic [31:0] m_rd;

  function automatic logic [31:0] m_status();
    return {27'd0, m_rx_ovf, m_tx_ovf, m_txq.size() == DEPTH,
            m_txq.size() == 0, m_rxq.size() != 0};
  endfunction

  always @(posedge clk or posedge rst) begin : model_step
    logic [31:0] st;
    logic        tx_pop, rx_pop, rx_room;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_tx_ovf = 1'b0;
      m_rx_ovf = 1'b0;
      m_baud   = 32'd107;
      m_rd     = 32'd0;
    end else begin
      st      = m_status();
      tx_pop  = (m_txq.size() > 0) && tx_rdy;
      rx_room = m_rxq.size() < DEPTH;
      rx_pop  = 1'b0;
      if (rd_en) begin
        case (rd_addr[3:2])
          2'd0: begin
            if (m_rxq.size() > 0) begin
              m_rd   = {24'd0, m_rxq[0]};
              rx_pop = 1'b1;
            end else m_rd = 32'd0;
          end
          2'd1:    m_rd = st;
          2'd2:    m_rd = m_baud;
          default: m_rd = 32'd0;
        endcase
      end
      if (tx_pop) void'(m_txq.pop_front());
      if (|be) begin
        case (wr_addr[3:2])
          2'd0: if (be[0]) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(wr_data[7:0]);
            else m_tx_ovf = 1'b1;
          end
          2'd1: begin
            if (wr_data[3]) m_tx_ovf = 1'b0;
            if (wr_data[4]) m_rx_ovf = 1'b0;
          end
          2'd2: for (int b = 0; b < 4; b++)
                  if (be[b]) m_baud[8*b +: 8] = wr_data[8*b +: 8];
          default: ;
        endcase
      end
      if (rx_pop) void'(m_rxq.pop_front());
      if (rx_vld) begin
        if (rx_room) m_rxq.push_back(rx_data);
        else m_rx_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, well after the active edge.
  always @(posedge clk) begin
    #2;
    check("cyc_rd_data", rd_data, m_rd);
    check("cyc_tx_vld", {31'd0, tx_vld}, {31'd0, m_txq.size() != 0});
    check("cyc_tx_data", {24'd0, tx_data}, (m_txq.size() != 0) ? {24'd0, m_txq[0]} : 32'd0);
    check("cyc_rx_rdy", {31'd0, rx_rdy}, {31'd0, m_rxq.size() < DEPTH});
    check("cyc_baud", baud, m_baud);
  end

  // ---------------- directed stimulus (called at a negedge) ----------------
  task automatic write_reg(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be_v);
    wr_addr = {28'd0, off, 2'b00};
    wr_data = d;
    be      = be_v;
    @(negedge clk);
    be      = 4'd0;
  endtask

  task automatic read_reg(input logic [1:0] off, output logic [31:0] d);
    rd_addr = {28'd0, off, 2'b00};
    rd_en   = 1'b1;
    @(negedge clk);
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  logic [31:0] r;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_baud", baud, 32'd107);
    check("rst_rx_rdy", {31'd0, rx_rdy}, 32'd1);
    check("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    read_reg(2'd1, r);
    check("rst_status", r, 32'h2);

    // Back-to-back TX bytes with the UART ready
    tx_rdy = 1'b1;
    write_reg(2'd0, 32'h41, 4'hF);
    check("tx_first_byte", {24'd0, tx_data}, 32'h41);
    write_reg(2'd0, 32'h42, 4'hF);
    check("tx_second_byte", {24'd0, tx_data}, 32'h42);
    @(negedge clk);
    check("tx_drained_vld", {31'd0, tx_vld}, 32'd0);
    read_reg(2'd1, r);
    check("tx_drained_status", r, 32'h2);

    // TX overflow with the UART stalled
    tx_rdy = 1'b0;
    for (int i = 0; i < 9; i++) write_reg(2'd0, 32'h10 + 32'(i), 4'h1);
    read_reg(2'd1, r);
    check("tx_full_ovf_status", r, 32'hC);
    check("tx_full_head", {24'd0, tx_data}, 32'h10);
    write_reg(2'd1, 32'h8, 4'hF);
    read_reg(2'd1, r);
    check("tx_ovf_cleared", r, 32'h4);
    tx_rdy = 1'b1;
    repeat (DEPTH) @(negedge clk);
    tx_rdy = 1'b0;
    read_reg(2'd1, r);
    check("tx_after_drain", r, 32'h2);

    // RX bytes and reads, including read of an empty FIFO
    rx_vld = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rx_data = 8'hAA;
    @(negedge clk);
    rx_vld = 1'b0;
    read_reg(2'd0, r);
    check("rx_read_0", r, 32'h55);
    read_reg(2'd0, r);
    check("rx_read_1", r, 32'hAA);
    read_reg(2'd0, r);
    check("rx_read_empty", r, 32'h0);
    read_reg(2'd1, r);
    check("rx_empty_bit0", {31'd0, r[0]}, 32'd0);
    check("rx_empty_status", r, 32'h2);

    // RX full with vld held one extra cycle
    rx_vld = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h60 + 8'(i);
      @(negedge clk);
    end
    rx_vld = 1'b0;
    check("rx_full_rdy", {31'd0, rx_rdy}, 32'd0);
    read_reg(2'd1, r);
    check("rx_full_ovf_status", r, 32'h13);
    read_reg(2'd0, r);
    check("rx_full_pop", r, 32'h60);
    check("rx_rdy_after_pop", {31'd0, rx_rdy}, 32'd1);
    write_reg(2'd1, 32'h10, 4'hF);
    for (int i = 1; i < DEPTH; i++) begin
      read_reg(2'd0, r);
      check("rx_drain", r, 32'h60 + 32'(i));
    end
    read_reg(2'd1, r);
    check("rx_ovf_cleared", r, 32'h2);

    // Baud register lanes, reserved slot
    write_reg(2'd2, 32'h0000_0036, 4'h1);
    check("baud_lane0", baud, 32'h0000_0036);
    write_reg(2'd2, 32'h1234_5678, 4'hA);
    check("baud_lanes13", baud, 32'h1200_5636);
    read_reg(2'd2, r);
    check("baud_read", r, 32'h1200_5636);
    write_reg(2'd3, 32'hFFFF_FFFF, 4'hF);
    read_reg(2'd3, r);
    check("rsvd_read", r, 32'h0);
    check("rsvd_no_side_effect", baud, 32'h1200_5636);

    // Asynchronous reset with TX half full
    for (int i = 0; i < DEPTH / 2; i++) write_reg(2'd0, 32'h70 + 32'(i), 4'h1);
    check("pre_rst_tx_vld", {31'd0, tx_vld}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    check("async_rst_baud", baud, 32'd107);
    check("async_rst_rx_rdy", {31'd0, rx_rdy}, 32'd1);
    check("async_rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_reg(2'd1, r);
    check("post_rst_status", r, 32'h2);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
